// File: rtl/ga_pkg.sv
// Shared gate-array constants: screen modes, pixels per byte, pen masks.
package ga_pkg;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;

  // Pen bits that survive in each mode; the rest are forced to 0.
  localparam logic [3:0] PEN_MASK_M0 = 4'hF;
  localparam logic [3:0] PEN_MASK_M1 = 4'h3;
  localparam logic [3:0] PEN_MASK_M2 = 4'h1;
  localparam logic [3:0] PEN_MASK_M3 = 4'h3;

  function automatic logic [3:0] pix_per_byte(input logic [1:0] mode);
    logic [3:0] n;
    case (mode)
      MODE_0:  n = 4'd2;
      MODE_1:  n = 4'd4;
      MODE_2:  n = 4'd8;
      default: n = 4'd2;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] last_slot(input logic [1:0] mode);
    logic [3:0] n;
    n = pix_per_byte(mode) - 4'd1;
    return n[2:0];
  endfunction

  function automatic logic [3:0] pen_mask(input logic [1:0] mode);
    logic [3:0] m;
    case (mode)
      MODE_0:  m = PEN_MASK_M0;
      MODE_1:  m = PEN_MASK_M1;
      MODE_2:  m = PEN_MASK_M2;
      default: m = PEN_MASK_M3;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/video_pack_scatter.sv
// Places one pen's bits at the byte positions the gate array reads them from
// for a given slot. Slots beyond the mode's last slot produce an empty mask.
module video_pack_scatter
  import ga_pkg::*;
(
  input  logic [3:0] pen,
  input  logic [2:0] slot,
  input  logic [1:0] mode,
  output logic [7:0] mask
);

  logic [3:0] p;
  logic [7:0] base;

  // Build the slot-0 pattern for the mode, then shift right by the slot.
  always_comb begin
    p    = pen & pen_mask(mode);
    base = 8'h00;
    case (mode)
      MODE_2:  base = {p[0], 7'b0};
      MODE_1:  base = {p[0], 3'b0, p[1], 3'b0};
      default: base = {p[0], 1'b0, p[2], 1'b0, p[1], 1'b0, p[3], 1'b0};
    endcase
    mask = (slot <= last_slot(mode)) ? (base >> slot) : 8'h00;
  end

endmodule

// File: rtl/video_pack.sv
// Packs a stream of pen indices into CPC screen bytes for modes 0..3.
//
// Handshake: an item moves across an interface on a rising CLK_n edge where
// its VALID and READY are both 1. VALID, once raised, holds its data stable
// until taken. PIX_READY comes from registered state only; it never depends
// combinationally on BYTE_READY.
module video_pack
  import ga_pkg::*;
#(
  parameter logic [3:0] PAD_PEN = 4'd0
) (
  input  logic       CLK_n,
  input  logic       RESET_n,
  input  logic [1:0] MODE,
  input  logic [3:0] PIX,
  input  logic       PIX_VALID,
  output logic       PIX_READY,
  input  logic       FLUSH,
  output logic [7:0] BYTE,
  output logic       BYTE_VALID,
  input  logic       BYTE_READY
);

  logic [7:0] asm_q;
  logic [2:0] slot_q;
  logic [1:0] lmode_q;
  logic [7:0] byte_q;
  logic       byte_valid_q;
  logic       flush_pend_q;

  logic [1:0] eff_mode;
  logic [7:0] pix_bits;
  logic [7:0] asm_acc;
  logic       accept;
  logic       complete_nat;
  logic       flush_set;
  logic       flush_emit;
  logic [7:0] pad_mask [8];
  logic [7:0] pad_fill;

  // A full output register only blocks the final slot; pending flush blocks all.
  always_comb begin
    PIX_READY = ((slot_q != last_slot(lmode_q)) | ~byte_valid_q) & ~flush_pend_q;
  end

  video_pack_scatter u_pix (
    .pen  (PIX),
    .slot (slot_q),
    .mode (eff_mode),
    .mask (pix_bits)
  );

  // One scatter per slot position for the padding pen, in the latched mode.
  for (genvar g = 0; g < 8; g++) begin : g_pad
    video_pack_scatter u_pad (
      .pen  (PAD_PEN),
      .slot (3'(g)),
      .mode (lmode_q),
      .mask (pad_mask[g])
    );
  end

  // Accept, completion and flush decisions for this cycle.
  always_comb begin
    eff_mode     = (slot_q == 3'd0) ? MODE : lmode_q;
    accept       = PIX_VALID & PIX_READY;
    asm_acc      = asm_q | pix_bits;
    complete_nat = accept & (slot_q == last_slot(eff_mode));
    flush_set    = FLUSH & ((slot_q != 3'd0) | accept) & ~complete_nat;
    flush_emit   = flush_pend_q & ~byte_valid_q;
    pad_fill     = 8'h00;
    for (int s = 0; s < 8; s++) begin
      if (3'(s) >= slot_q) pad_fill = pad_fill | pad_mask[s];
    end
  end

  // Assembly register, slot counter and mode latch.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      asm_q   <= 8'h00;
      slot_q  <= 3'd0;
      lmode_q <= MODE_0;
    end else if (accept) begin
      if (slot_q == 3'd0) lmode_q <= MODE;
      if (complete_nat) begin
        asm_q  <= 8'h00;
        slot_q <= 3'd0;
      end else begin
        asm_q  <= asm_acc;
        slot_q <= slot_q + 3'd1;
      end
    end else if (flush_emit) begin
      asm_q  <= 8'h00;
      slot_q <= 3'd0;
    end
  end

  // Flush request held until the output register is free to take the byte.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      flush_pend_q <= 1'b0;
    end else if (flush_emit) begin
      flush_pend_q <= 1'b0;
    end else if (flush_set) begin
      flush_pend_q <= 1'b1;
    end
  end

  // Output register: load on completion or flush, clear on consumption.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
    end else if (complete_nat) begin
      byte_q       <= asm_acc;
      byte_valid_q <= 1'b1;
    end else if (flush_emit) begin
      byte_q       <= asm_q | pad_fill;
      byte_valid_q <= 1'b1;
    end else if (byte_valid_q && BYTE_READY) begin
      byte_valid_q <= 1'b0;
    end
  end

  assign BYTE       = byte_q;
  assign BYTE_VALID = byte_valid_q;

endmodule

// File: tb/tb_video_pack.sv
// Directed bench for video_pack: inputs change 1ns after posedge, the byte
// scoreboard samples on negedge.
module tb_video_pack;

  logic       CLK_n;
  logic       RESET_n;
  logic [1:0] MODE;
  logic [3:0] PIX;
  logic       PIX_VALID;
  logic       PIX_READY;
  logic       FLUSH;
  logic [7:0] BYTE;
  logic       BYTE_VALID;
  logic       BYTE_READY;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int t0;
  logic [7:0] exp_q[$];

  video_pack #(.PAD_PEN(4'd0)) dut (
    .CLK_n      (CLK_n),
    .RESET_n    (RESET_n),
    .MODE       (MODE),
    .PIX        (PIX),
    .PIX_VALID  (PIX_VALID),
    .PIX_READY  (PIX_READY),
    .FLUSH      (FLUSH),
    .BYTE       (BYTE),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_READY (BYTE_READY)
  );

  // Clock and cycle counter
  initial CLK_n = 1'b0;
  always #5 CLK_n = ~CLK_n;
  always @(posedge CLK_n) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every consumed byte must match the head of exp_q.
  always @(negedge CLK_n) begin
    if (RESET_n && BYTE_VALID && BYTE_READY) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $error("FAIL unexpected_byte: observed %0h expected none", BYTE);
      end else begin
        check("byte_data", {24'h0, BYTE}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_n);
      #1;
    end
  endtask

  // Present one pixel and hold it until it is accepted (bounded).
  task automatic send_pix(input logic [3:0] pen, input logic [1:0] mode);
    int n;
    n = 0;
    PIX = pen;
    MODE = mode;
    PIX_VALID = 1'b1;
    @(negedge CLK_n);
    while (!PIX_READY && n < 50) begin
      @(negedge CLK_n);
      n++;
    end
    if (n >= 50) check("pix_accept_timeout", 32'(n), 32'd0);
    @(posedge CLK_n);
    #1;
    PIX_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step(1);
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    step(1);
  endtask

  initial begin
    RESET_n = 1'b0;
    MODE = 2'd0;
    PIX = 4'd0;
    PIX_VALID = 1'b0;
    FLUSH = 1'b0;
    BYTE_READY = 1'b1;
    step(3);
    check("reset_byte", {24'h0, BYTE}, 32'h00);
    check("reset_valid", {31'h0, BYTE_VALID}, 32'd0);
    RESET_n = 1'b1;
    step(1);
    check("reset_ready", {31'h0, PIX_READY}, 32'd1);

    // Mode 2, 1,0,1,1,0,0,1,0 -> 1011_0010
    exp_q.push_back(8'hB2);
    t0 = cyc;
    send_pix(1, 2); send_pix(0, 2); send_pix(1, 2); send_pix(1, 2);
    send_pix(0, 2); send_pix(0, 2); send_pix(1, 2); send_pix(0, 2);
    check("m2_accept_cycles", 32'(cyc - t0), 32'd8);
    check("m2_valid_latency", {31'h0, BYTE_VALID}, 32'd1);
    step(1);
    check("m2_valid_one_cycle", {31'h0, BYTE_VALID}, 32'd0);
    check("m2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Mode 0: 5 -> bits 7,5 (A0); 10 at slot 1 -> bits 2,0 (05)
    exp_q.push_back(8'hA5);
    send_pix(5, 0); send_pix(10, 0);
    // Mode 1: 3->88, 0, 1 at slot2 ->20, 2 at slot3 ->01
    exp_q.push_back(8'hA9);
    send_pix(3, 1); send_pix(0, 1); send_pix(1, 1); send_pix(2, 1);
    // Mode 3: 7 masked to 3 -> bits 7,3 (88); 2 at slot 1 -> bit 2 (04)
    exp_q.push_back(8'h8C);
    send_pix(7, 3); send_pix(2, 3);
    drain();

    // Backpressure: 16 pens of 1 in mode 2 with the consumer stalled
    BYTE_READY = 1'b0;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 15; i++) send_pix(1, 2);
    PIX = 4'd1;
    PIX_VALID = 1'b1;
    step(3);
    check("bp_ready_low", {31'h0, PIX_READY}, 32'd0);
    check("bp_byte_held", {24'h0, BYTE}, 32'hFF);
    check("bp_valid_held", {31'h0, BYTE_VALID}, 32'd1);
    BYTE_READY = 1'b1;
    step(1);
    check("bp_bubble_valid", {31'h0, BYTE_VALID}, 32'd0);
    check("bp_bubble_ready", {31'h0, PIX_READY}, 32'd1);
    send_pix(1, 2);
    check("bp_second_valid", {31'h0, BYTE_VALID}, 32'd1);
    drain();

    // Flush after three mode-2 pens with PAD_PEN=0 -> 1110_0000
    exp_q.push_back(8'hE0);
    send_pix(1, 2); send_pix(1, 2); send_pix(1, 2);
    FLUSH = 1'b1;
    step(1);
    FLUSH = 1'b0;
    check("flush_pend_ready", {31'h0, PIX_READY}, 32'd0);
    drain();
    // Next byte restarts at slot 0 with the new mode latched
    exp_q.push_back(8'hA9);
    send_pix(3, 1); send_pix(0, 1); send_pix(1, 1); send_pix(2, 1);
    drain();
    // Flush with nothing assembled does nothing
    FLUSH = 1'b1;
    step(1);
    FLUSH = 1'b0;
    step(4);
    check("idle_flush_valid", {31'h0, BYTE_VALID}, 32'd0);
    check("idle_flush_ready", {31'h0, PIX_READY}, 32'd1);

    // Flush with the third pixel while the output register is full
    BYTE_READY = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hE0);
    send_pix(5, 0); send_pix(10, 0);
    send_pix(1, 2); send_pix(1, 2);
    PIX = 4'd1;
    MODE = 2'd2;
    PIX_VALID = 1'b1;
    FLUSH = 1'b1;
    step(1);
    PIX_VALID = 1'b0;
    FLUSH = 1'b0;
    step(2);
    check("full_flush_ready", {31'h0, PIX_READY}, 32'd0);
    check("full_flush_held", {24'h0, BYTE}, 32'hA5);
    BYTE_READY = 1'b1;
    drain();
    check("full_flush_ready_back", {31'h0, PIX_READY}, 32'd1);

    // Mode change after slot 0 is ignored for the rest of the byte
    exp_q.push_back(8'hA5);
    send_pix(5, 0); send_pix(10, 2);
    drain();

    // Reset in the middle of a byte with a byte waiting in the output
    BYTE_READY = 1'b0;
    send_pix(3, 1); send_pix(0, 1); send_pix(1, 1); send_pix(2, 1);
    send_pix(3, 1); send_pix(3, 1);
    check("pre_reset_valid", {31'h0, BYTE_VALID}, 32'd1);
    RESET_n = 1'b0;
    #1;
    check("async_reset_byte", {24'h0, BYTE}, 32'h00);
    check("async_reset_valid", {31'h0, BYTE_VALID}, 32'd0);
    step(1);
    RESET_n = 1'b1;
    BYTE_READY = 1'b1;
    step(1);
    exp_q.push_back(8'h01);
    for (int i = 0; i < 7; i++) send_pix(0, 2);
    send_pix(1, 2);
    drain();

    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
